soft_gtv_param: RTL and testbench

- Parametrised successor of the single-channel soft gate/tick counter.
- An up/down counter of configurable width steps on either a programmable timebase tick or a rising edge of an external event.
- Adds a programmable modulo limit, a wrap or saturate choice, ping-pong modes, synchronous load, and a terminal-count pulse.
- Sits between the board buttons/switches and the display/LED driver that consumes count.

---
 rtl/soft_gtv_param_if.sv | 29 ++
 rtl/soft_gtv_param.sv | 140 ++++++++++++++
 tb/tb_soft_gtv_param.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soft_gtv_param_if.sv
// Handshake bundle for soft_gtv_param: controls in, count/pulses out.
// The master drives buttons, mode and load; the counter is the slave.
interface soft_gtv_param_if #(
   parameter int WIDTH = 8
);
   logic             spd_btn;
   logic             spd_clr;
   logic [2:0]       mode;
   logic             evnt;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             tc;
   logic             dir;

   modport master (
      output spd_btn, spd_clr, mode, evnt,
      output load, load_val, max_val,
      input  count, tick, tc, dir
   );

   modport slave (
      input  spd_btn, spd_clr, mode, evnt,
      input  load, load_val, max_val,
      output count, tick, tc, dir
   );
endinterface

// File: rtl/soft_gtv_param.sv
// Parametrised up/down/ping-pong counter stepped by a speed-adjustable
// timebase or by external event edges, with modulo limit and load.
module soft_gtv_param #(
   parameter int WIDTH     = 8,
   parameter int TICK_BASE = 250000,
   parameter int TICK_W    = 25,
   parameter int SPD_W     = 29,
   parameter int SPD_SHIFT = 4,
   parameter bit SAT       = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   soft_gtv_param_if.slave  bus
);
   localparam int SW = ((SPD_W > TICK_W) ? SPD_W : TICK_W) + 1;
   localparam logic [SW-1:0] PMAX = (SW'(1) << TICK_W) - SW'(1);

   typedef enum logic [1:0] {K_NONE, K_DN, K_UP, K_PP} kind_t;

   logic [SPD_W-1:0]  spd;
   logic [TICK_W-1:0] base;
   logic [SW-1:0]     per_sum;
   logic [TICK_W-1:0] per;
   logic              flag;
   logic              evnt_ff;
   logic              rise;
   kind_t             kind;
   logic              src;
   logic [WIDTH-1:0]  cnt_n;
   logic [WIDTH-1:0]  dec;
   logic              dir_n;
   logic              tc_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         spd <= '0;
      end else if (bus.spd_clr) begin
         spd <= '0;
      end else if (bus.spd_btn && spd != '1) begin
         spd <= spd + SPD_W'(1);
      end
   end

   // Wide sum so a large speed value clamps instead of wrapping the period.
   assign per_sum = SW'(TICK_BASE) + SW'(spd >> SPD_SHIFT);
   assign per     = (per_sum > PMAX) ? PMAX[TICK_W-1:0]
                                     : per_sum[TICK_W-1:0];
   assign flag    = (base >= per - TICK_W'(1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         base <= '0;
         bus.tick <= 1'b0;
      end else begin
         base <= flag ? '0 : base + TICK_W'(1);
         bus.tick <= flag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) evnt_ff <= 1'b1;
      else      evnt_ff <= bus.evnt;
   end

   assign rise = bus.evnt & ~evnt_ff;

   always_comb begin
      kind = K_NONE;
      src  = 1'b0;
      unique case (bus.mode)
         3'd0: begin kind = K_DN; src = flag; end
         3'd1: begin kind = K_UP; src = flag; end
         3'd3: begin kind = K_PP; src = flag; end
         3'd4: begin kind = K_DN; src = rise; end
         3'd5: begin kind = K_UP; src = rise; end
         3'd6: begin kind = K_PP; src = rise; end
         default: begin kind = K_NONE; src = 1'b0; end
      endcase
   end

   assign dec = bus.count - WIDTH'(1);

   always_comb begin
      cnt_n = bus.count;
      dir_n = bus.dir;
      tc_n  = 1'b0;
      if (bus.load) begin
         cnt_n = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
      end else if (src) begin
         unique case (kind)
            K_UP: begin
               if (bus.count < bus.max_val)
                  cnt_n = bus.count + WIDTH'(1);
               else
                  cnt_n = SAT ? bus.max_val : '0;
               tc_n = (cnt_n == bus.max_val);
            end
            K_DN: begin
               if (bus.count != '0)
                  cnt_n = (dec > bus.max_val) ? bus.max_val : dec;
               else
                  cnt_n = SAT ? '0 : bus.max_val;
               tc_n = (cnt_n == '0);
            end
            K_PP: begin
               if (bus.max_val == '0) begin
                  cnt_n = '0;
               end else if (bus.dir && bus.count >= bus.max_val) begin
                  cnt_n = bus.max_val - WIDTH'(1);
                  dir_n = 1'b0;
               end else if (!bus.dir && bus.count == '0) begin
                  cnt_n = WIDTH'(1);
                  dir_n = 1'b1;
               end else if (bus.dir) begin
                  cnt_n = bus.count + WIDTH'(1);
                  tc_n  = (cnt_n == bus.max_val);
               end else begin
                  cnt_n = dec;
                  tc_n  = (cnt_n == '0);
               end
            end
            default: begin
               cnt_n = bus.count;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.count <= '0;
         bus.tc    <= 1'b0;
         bus.dir   <= 1'b1;
      end else begin
         bus.count <= cnt_n;
         bus.tc    <= tc_n;
         bus.dir   <= dir_n;
      end
   end
endmodule

// File: tb/tb_soft_gtv_param.sv
// Directed bench for soft_gtv_param: one wrapping and one saturating
// instance, each with a 4-cycle base timebase and 4-bit count.
module tb_soft_gtv_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   soft_gtv_param_if #(.WIDTH(4)) i0 ();
   soft_gtv_param_if #(.WIDTH(4)) i1 ();

   soft_gtv_param #(
      .WIDTH(4), .TICK_BASE(4), .TICK_W(8),
      .SPD_W(8), .SPD_SHIFT(2), .SAT(1'b0)
   ) d0 (.clk(clk), .rst(rst), .bus(i0));

   soft_gtv_param #(
      .WIDTH(4), .TICK_BASE(4), .TICK_W(8),
      .SPD_W(8), .SPD_SHIFT(2), .SAT(1'b1)
   ) d1 (.clk(clk), .rst(rst), .bus(i1));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(output bit found);
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         cyc();
         if (i0.tick) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i0.evnt = 1'b1;
      i0.mode = 3'd5;
      repeat (3) cyc();
      checks++;
      if (i0.count !== 4'd0) begin
         errors++;
         $display("FAIL reset_count got %0d exp 0", i0.count);
      end
      checks++;
      if (i0.tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick got %b exp 0", i0.tick);
      end
      checks++;
      if (i0.tc !== 1'b0) begin
         errors++;
         $display("FAIL reset_tc got %b exp 0", i0.tc);
      end
      checks++;
      if (i0.dir !== 1'b1) begin
         errors++;
         $display("FAIL reset_dir got %b exp 1", i0.dir);
      end
      rst = 1'b1;
      cyc();
      cyc();
      checks++;
      if (i0.count !== 4'd0) begin
         errors++;
         $display("FAIL held_evnt got %0d exp 0", i0.count);
      end
      i0.evnt = 1'b0;
      cyc();
      checks++;
      if (i0.count !== 4'd0) begin
         errors++;
         $display("FAIL evnt_fall got %0d exp 0", i0.count);
      end
      i0.evnt = 1'b1;
      cyc();
      checks++;
      if (i0.count !== 4'd1) begin
         errors++;
         $display("FAIL evnt_rise got %0d exp 1", i0.count);
      end
      i0.evnt = 1'b0;
   endtask

   task automatic test_timed_up();
      bit       found;
      bit       at;
      bit [3:0] exp;
      i0.mode = 3'd2;
      i0.max_val = 4'd5;
      i0.load_val = 4'd0;
      i0.load = 1'b1;
      cyc();
      i0.load = 1'b0;
      checks++;
      if (i0.count !== 4'd0) begin
         errors++;
         $display("FAIL up_load got %0d exp 0", i0.count);
      end
      wait_tick(found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL up_tick_timeout got none exp tick");
      end
      i0.mode = 3'd1;
      exp = 4'd0;
      for (int k = 1; k <= 24; k++) begin
         cyc();
         at = (k % 4 == 0);
         if (at) exp = (exp == 4'd5) ? 4'd0 : exp + 4'd1;
         checks++;
         if (i0.count !== exp || i0.tick !== at ||
             i0.tc !== (at && exp == 4'd5)) begin
            errors++;
            $display("FAIL up_step k=%0d got c=%0d t=%b tc=%b exp c=%0d t=%b",
                     k, i0.count, i0.tick, i0.tc, exp, at);
         end
      end
      i0.mode = 3'd2;
   endtask

   task automatic test_sat_down();
      bit [3:0] ec [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
      bit       et [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      i1.mode = 3'd4;
      i1.load_val = 4'd2;
      i1.load = 1'b1;
      cyc();
      i1.load = 1'b0;
      checks++;
      if (i1.count !== 4'd2) begin
         errors++;
         $display("FAIL sat_load got %0d exp 2", i1.count);
      end
      for (int i = 0; i < 4; i++) begin
         i1.evnt = 1'b1;
         cyc();
         checks++;
         if (i1.count !== ec[i] || i1.tc !== et[i]) begin
            errors++;
            $display("FAIL sat_step %0d got c=%0d tc=%b exp c=%0d tc=%b",
                     i, i1.count, i1.tc, ec[i], et[i]);
         end
         i1.evnt = 1'b0;
         cyc();
         checks++;
         if (i1.tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_tc_width %0d got %b exp 0", i, i1.tc);
         end
      end
   endtask

   task automatic test_ping_pong();
      bit [3:0] ec [7] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
      bit       ed [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      bit       et [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      bit found;
      int n;
      i0.mode = 3'd2;
      i0.max_val = 4'd3;
      i0.load_val = 4'd0;
      i0.load = 1'b1;
      cyc();
      i0.load = 1'b0;
      wait_tick(found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL pp_tick_timeout got none exp tick");
      end
      i0.mode = 3'd3;
      for (int k = 1; k <= 28; k++) begin
         cyc();
         checks++;
         if (k % 4 == 0) begin
            n = k / 4 - 1;
            if (i0.count !== ec[n] || i0.dir !== ed[n] || i0.tc !== et[n]) begin
               errors++;
               $display("FAIL pp_step %0d got c=%0d d=%b tc=%b exp c=%0d d=%b tc=%b",
                        n, i0.count, i0.dir, i0.tc, ec[n], ed[n], et[n]);
            end
         end else if (i0.tc !== 1'b0) begin
            errors++;
            $display("FAIL pp_idle k=%0d got tc=%b exp 0", k, i0.tc);
         end
      end
      i0.mode = 3'd2;
   endtask

   task automatic test_speed();
      bit found;
      i0.mode = 3'd2;
      i0.spd_btn = 1'b1;
      repeat (8) cyc();
      i0.spd_btn = 1'b0;
      wait_tick(found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL spd_tick_timeout got none exp tick");
      end
      for (int k = 1; k <= 6; k++) begin
         cyc();
         checks++;
         if (i0.tick !== (k == 6)) begin
            errors++;
            $display("FAIL spd_period6 k=%0d got %b exp %b", k, i0.tick, k == 6);
         end
      end
      repeat (5) cyc();
      i0.spd_clr = 1'b1;
      cyc();
      i0.spd_clr = 1'b0;
      checks++;
      if (i0.tick !== 1'b1) begin
         errors++;
         $display("FAIL spd_clr_tick got %b exp 1", i0.tick);
      end
      for (int k = 1; k <= 4; k++) begin
         cyc();
         checks++;
         if (i0.tick !== (k == 4)) begin
            errors++;
            $display("FAIL spd_period4 k=%0d got %b exp %b", k, i0.tick, k == 4);
         end
      end
   endtask

   task automatic test_load_priority();
      bit found;
      i0.mode = 3'd2;
      i0.max_val = 4'd7;
      wait_tick(found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL ld_tick_timeout got none exp tick");
      end
      repeat (3) cyc();
      i0.mode = 3'd1;
      i0.load_val = 4'd9;
      i0.load = 1'b1;
      cyc();
      i0.load = 1'b0;
      i0.mode = 3'd2;
      checks++;
      if (i0.tick !== 1'b1 || i0.count !== 4'd7 || i0.tc !== 1'b0) begin
         errors++;
         $display("FAIL ld_prio got t=%b c=%0d tc=%b exp t=1 c=7 tc=0",
                  i0.tick, i0.count, i0.tc);
      end
   endtask

   task automatic test_wrap_down();
      i0.mode = 3'd2;
      i0.load_val = 4'd0;
      i0.load = 1'b1;
      cyc();
      i0.load = 1'b0;
      i0.mode = 3'd4;
      i0.evnt = 1'b1;
      cyc();
      checks++;
      if (i0.count !== 4'd7 || i0.tc !== 1'b0) begin
         errors++;
         $display("FAIL wrap_down got c=%0d tc=%b exp c=7 tc=0", i0.count, i0.tc);
      end
      i0.evnt = 1'b0;
      i0.mode = 3'd5;
      cyc();
      i0.evnt = 1'b1;
      cyc();
      checks++;
      if (i0.count !== 4'd0 || i0.tc !== 1'b0) begin
         errors++;
         $display("FAIL wrap_up got c=%0d tc=%b exp c=0 tc=0", i0.count, i0.tc);
      end
      i0.evnt = 1'b0;
      i0.mode = 3'd2;
   endtask

   initial begin
      i0.spd_btn = 1'b0;
      i0.spd_clr = 1'b0;
      i0.mode = 3'd5;
      i0.evnt = 1'b1;
      i0.load = 1'b0;
      i0.load_val = 4'd0;
      i0.max_val = 4'd15;
      i1.spd_btn = 1'b0;
      i1.spd_clr = 1'b0;
      i1.mode = 3'd2;
      i1.evnt = 1'b0;
      i1.load = 1'b0;
      i1.load_val = 4'd0;
      i1.max_val = 4'd15;
      test_reset();
      test_timed_up();
      test_sat_down();
      test_ping_pong();
      test_speed();
      test_load_priority();
      test_wrap_down();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
